// File: rtl/qos_pkg.sv
// qos_pkg: shared FSM state codes and arbitration mode constants for the QoS VC switch
package qos_pkg;
   localparam logic [1:0] ST_RESET  = 2'd0;
   localparam logic [1:0] ST_INIT   = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;
   localparam logic [1:0] ST_ACTIVE = 2'd3;
   localparam int ARB_RR     = 0;
   localparam int ARB_STRICT = 1;
endpackage

// File: rtl/qos_sync_fifo.sv
// qos_sync_fifo: first-word-fall-through FIFO with occupancy count and threshold flag
//  clk/reset: clock, async active-high reset; push/din: write; pop/dout: read head (0 when empty)
//  thr: almost-full threshold; count/full/empty/almost_full: status; err: push to full or pop of empty
module qos_sync_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   input  logic [$clog2(DEPTH):0]     thr,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       err
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] count_q, count_d;
   logic do_push, do_pop;
   assign full        = count_q == (PTR_W+1)'(DEPTH);
   assign empty       = count_q == '0;
   assign almost_full = count_q >= thr;
   assign count       = count_q;
   assign dout        = empty ? '0 : mem_q[rd_ptr_q];
   assign err         = (push & full & ~pop) | (pop & empty);
   // a pop on a full FIFO frees the slot the simultaneous push lands in
   always_comb begin
      do_push  = push & (~full | pop);
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/qos_vc_switch.sv
// qos_vc_switch: NCH ingress VC FIFOs arbitrated one word/cycle into NCH egress FIFOs by destination
//  clk/reset: clock, async active-high reset; init/umbral_high: enter INIT, load almost-full threshold
//  push_in/data_in/full_in: ingress side; pop_out/data_out/empty_out: egress side (FWFT)
//  req/idx -> valid/cnt_data: counter read (idx<NCH egress pops, idx==NCH total grants)
//  active_out/idle_out: FSM state flags; error_out: one-cycle error pulse
module qos_vc_switch import qos_pkg::*; #(
   parameter int NCH      = 4,
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 5,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init,
   input  logic [$clog2(DEPTH):0]  umbral_high,
   input  logic [NCH-1:0]          push_in,
   input  logic [NCH*DATA_W-1:0]   data_in,
   output logic [NCH-1:0]          full_in,
   input  logic [NCH-1:0]          pop_out,
   output logic [NCH*DATA_W-1:0]   data_out,
   output logic [NCH-1:0]          empty_out,
   input  logic                    req,
   input  logic [$clog2(NCH):0]    idx,
   output logic                    valid,
   output logic [CNT_W-1:0]        cnt_data,
   output logic                    active_out,
   output logic                    idle_out,
   output logic                    error_out
);
   localparam int DEST_W = $clog2(NCH);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int IDX_W  = DEST_W + 1;
   logic [1:0] state_q, state_d;
   logic [PTR_W:0] thr_q, thr_d;
   logic [DEST_W-1:0] ptr_q, ptr_d, gnt_idx, cand;
   logic [CNT_W-1:0] cnt_q [NCH+1];
   logic [CNT_W-1:0] cnt_d [NCH+1];
   logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
   logic valid_q, valid_d, error_q, error_d, gnt;
   logic [NCH-1:0] in_empty, in_err, in_pop, eg_empty, eg_full, eg_af, eg_err, eg_push, elig, unused_in_af;
   logic [DATA_W-1:0] in_head [NCH];
   logic [PTR_W:0] unused_cnt [2*NCH];
   logic [DATA_W-1:0] gnt_word;
   assign gnt_word = in_head[gnt_idx];
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DEST_W-1:0] dest;
      assign dest       = in_head[i][DATA_W-1 -: DEST_W];
      assign elig[i]    = ~in_empty[i] & ~eg_af[dest] & ~eg_full[dest] & (state_q == ST_ACTIVE);
      assign in_pop[i]  = gnt & (gnt_idx == DEST_W'(i));
      assign eg_push[i] = gnt & (gnt_word[DATA_W-1 -: DEST_W] == DEST_W'(i));
      qos_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in (
         .clk(clk), .reset(reset), .push(push_in[i]), .pop(in_pop[i]),
         .din(data_in[i*DATA_W +: DATA_W]), .thr(thr_q), .dout(in_head[i]), .count(unused_cnt[i]),
         .full(full_in[i]), .empty(in_empty[i]), .almost_full(unused_in_af[i]), .err(in_err[i]));
      qos_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_eg (
         .clk(clk), .reset(reset), .push(eg_push[i]), .pop(pop_out[i]),
         .din(gnt_word), .thr(thr_q), .dout(data_out[i*DATA_W +: DATA_W]), .count(unused_cnt[NCH+i]),
         .full(eg_full[i]), .empty(eg_empty[i]), .almost_full(eg_af[i]), .err(eg_err[i]));
   end
   // scan candidates from lowest priority to highest so the last hit wins
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = NCH; k >= 1; k--) begin
         cand = (ARB_MODE == ARB_STRICT) ? DEST_W'(k - 1) : DEST_W'(ptr_q + DEST_W'(k));
         if (elig[cand]) begin
            gnt     = 1'b1;
            gnt_idx = cand;
         end
      end
   end
   always_comb begin
      state_d = init ? ST_INIT :
                (state_q == ST_INIT) ? ST_IDLE :
                (state_q == ST_IDLE && !(&in_empty)) ? ST_ACTIVE :
                (state_q == ST_ACTIVE && (&in_empty) && !gnt) ? ST_IDLE : state_q;
      thr_d   = init ? umbral_high : thr_q;
      ptr_d   = gnt ? gnt_idx : ptr_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < NCH; i++)
         if (pop_out[i] && !eg_empty[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (gnt) cnt_d[NCH] = cnt_q[NCH] + CNT_W'(1);
      if (state_q == ST_INIT) cnt_d = '{default: '0};
      valid_d    = req & (idx <= IDX_W'(NCH));
      cnt_data_d = valid_d ? cnt_q[idx] : '0;
      error_d    = (|in_err) | (|eg_err) | (req & ~valid_d);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RESET;
         thr_q      <= (PTR_W+1)'(DEPTH - 1);
         ptr_q      <= DEST_W'(NCH - 1);
         cnt_q      <= '{default: '0};
         valid_q    <= 1'b0;
         cnt_data_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         cnt_data_q <= cnt_data_d;
         error_q    <= error_d;
      end
   end
   assign empty_out  = eg_empty;
   assign valid      = valid_q;
   assign cnt_data   = cnt_data_q;
   assign error_out  = error_q;
   assign active_out = state_q == ST_ACTIVE;
   assign idle_out   = state_q == ST_IDLE;
endmodule

// File: tb/tb_qos_vc_switch.sv
// tb_qos_vc_switch: scoreboard bench for round-robin and strict-priority switch instances
module tb_qos_vc_switch;
   logic clk = 1'b0, reset = 1'b1;
   logic init = 1'b0, req = 1'b0;
   logic [3:0] umbral_high = '0, push_in = '0, pop_out = '0, full_in, empty_out;
   logic [47:0] data_in = '0, data_out;
   logic [2:0] idx = '0;
   logic valid, active_out, idle_out, error_out;
   logic [4:0] cnt_data;
   logic s_init = 1'b0;
   logic [3:0] s_umbral = '0, s_push = '0, s_pop = '0, s_full, s_empty;
   logic [47:0] s_data_in = '0, s_data_out;
   logic s_valid, s_active, s_idle, s_error;
   logic [4:0] s_cnt;
   int n_cmp = 0, n_bad = 0;
   logic [11:0] exp_q [4][$];
   logic [11:0] s_exp_q [4][$];
   logic [4:0] rd_q [$];

   always #5 clk = ~clk;

   qos_vc_switch #(.ARB_MODE(0)) dut (
      .clk(clk), .reset(reset), .init(init), .umbral_high(umbral_high),
      .push_in(push_in), .data_in(data_in), .full_in(full_in),
      .pop_out(pop_out), .data_out(data_out), .empty_out(empty_out),
      .req(req), .idx(idx), .valid(valid), .cnt_data(cnt_data),
      .active_out(active_out), .idle_out(idle_out), .error_out(error_out));

   qos_vc_switch #(.ARB_MODE(1)) dut_s (
      .clk(clk), .reset(reset), .init(s_init), .umbral_high(s_umbral),
      .push_in(s_push), .data_in(s_data_in), .full_in(s_full),
      .pop_out(s_pop), .data_out(s_data_out), .empty_out(s_empty),
      .req(1'b0), .idx(3'd0), .valid(s_valid), .cnt_data(s_cnt),
      .active_out(s_active), .idle_out(s_idle), .error_out(s_error));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] w(input int d, input int c, input int k);
      logic [9:0] t;
      t = 10'(c * 16 + k);
      return {d[1:0], t};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int i, input int e);
      req = 1'b1;
      idx = 3'(i);
      rd_q.push_back(5'(e));
      tick();
      req = 1'b0;
   endtask

   // monitor: every accepted egress pop and every counter read is checked against the queues
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (pop_out[c] && !empty_out[c]) begin
            if (exp_q[c].size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL egress%0d_word: got %0h required none", c, data_out[c*12 +: 12]);
            end else chk($sformatf("egress%0d_word", c), data_out[c*12 +: 12], exp_q[c].pop_front());
         end
         if (s_pop[c] && !s_empty[c]) begin
            if (s_exp_q[c].size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL strict_egress%0d_word: got %0h required none", c, s_data_out[c*12 +: 12]);
            end else chk($sformatf("strict_egress%0d_word", c), s_data_out[c*12 +: 12], s_exp_q[c].pop_front());
         end
      end
      if (valid) begin
         if (rd_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cnt_read: got valid data %0d required no read", cnt_data);
         end else chk("cnt_read", cnt_data, rd_q.pop_front());
      end
   end

   initial begin
      repeat (2) tick();
      chk("rst_full_in", full_in, 4'h0);
      chk("rst_empty_out", empty_out, 4'hF);
      chk("rst_data_out", data_out, 48'h0);
      chk("rst_valid_cnt", {valid, cnt_data}, 6'h0);
      chk("rst_flags", {active_out, idle_out, error_out}, 3'b000);
      reset = 1'b0;
      tick();
      init = 1'b1; umbral_high = 4'd3; s_init = 1'b1; s_umbral = 4'd8;
      tick(); tick();
      init = 1'b0; s_init = 1'b0;
      tick();
      chk("init_idle", {idle_out, active_out}, 2'b10);
      rd(0, 0);
      rd(4, 0);
      // round robin: two words per ingress, all headed to egress 1
      for (int k = 0; k < 2; k++) begin
         push_in = 4'hF;
         for (int c = 0; c < 4; c++) data_in[c*12 +: 12] = w(1, c, k);
         tick();
      end
      push_in = '0;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) exp_q[1].push_back(w(1, c, k));
      repeat (6) tick();
      chk("rr_stall_active", active_out, 1'b1);
      rd(4, 3);
      pop_out[1] = 1'b1;
      tick();
      pop_out = '0;
      tick(); tick();
      rd(4, 4);
      rd(1, 1);
      pop_out[1] = 1'b1;
      repeat (16) tick();
      pop_out = '0;
      tick();
      chk("rr_back_idle", idle_out, 1'b1);
      rd(1, 8);
      rd(4, 8);
      // latency: one word on ingress 2 to egress 3
      push_in = 4'b0100;
      data_in[24 +: 12] = w(3, 2, 0);
      tick();
      push_in = '0;
      chk("lat_edge0_empty", empty_out[3], 1'b1);
      tick();
      chk("lat_edge1_empty", empty_out[3], 1'b1);
      tick();
      chk("lat_edge2_empty", empty_out[3], 1'b0);
      chk("lat_edge2_data", data_out[36 +: 12], w(3, 2, 0));
      exp_q[3].push_back(w(3, 2, 0));
      pop_out[3] = 1'b1;
      tick();
      pop_out = '0;
      // five words to egress 2, popped out
      for (int k = 0; k < 5; k++) begin
         push_in = 4'b0001;
         data_in[0 +: 12] = w(2, 0, 8 + k);
         exp_q[2].push_back(w(2, 0, 8 + k));
         tick();
      end
      push_in = '0;
      pop_out[2] = 1'b1;
      repeat (12) tick();
      pop_out = '0;
      rd(2, 5);
      rd(4, 14);
      rd(3, 1);
      rd(0, 0);
      req = 1'b1; idx = 3'd5;
      tick();
      req = 1'b0;
      chk("bad_idx_valid_data", {valid, cnt_data}, 6'h0);
      chk("bad_idx_error", error_out, 1'b1);
      tick();
      chk("bad_idx_error_clear", error_out, 1'b0);
      // fill ingress 0 while held in INIT so nothing drains
      init = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         push_in = 4'b0001;
         data_in[0 +: 12] = w(0, 0, 32 + k);
         exp_q[0].push_back(w(0, 0, 32 + k));
         tick();
         if (k == 6) chk("fill7_not_full", full_in[0], 1'b0);
      end
      chk("fill8_full", full_in[0], 1'b1);
      chk("fill8_no_error", error_out, 1'b0);
      data_in[0 +: 12] = w(0, 0, 40);
      tick();
      push_in = '0;
      chk("overflow_error", error_out, 1'b1);
      chk("overflow_still_full", full_in[0], 1'b1);
      tick();
      chk("overflow_error_clear", error_out, 1'b0);
      pop_out[0] = 1'b1;
      tick();
      pop_out = '0;
      chk("pop_empty_error_init", error_out, 1'b1);
      init = 1'b0;
      tick();
      rd(0, 0);
      rd(4, 0);
      pop_out[0] = 1'b1;
      repeat (16) tick();
      pop_out = '0;
      rd(0, 8);
      pop_out[0] = 1'b1;
      tick();
      pop_out = '0;
      chk("pop_empty_error", error_out, 1'b1);
      rd(0, 8);
      // reset with traffic in flight
      for (int k = 0; k < 3; k++) begin
         push_in = 4'hF;
         for (int c = 0; c < 4; c++) data_in[c*12 +: 12] = w(c, c, 48 + k);
         tick();
      end
      push_in = '0;
      tick(); tick();
      chk("midop_active", active_out, 1'b1);
      reset = 1'b1;
      #2;
      chk("midop_rst_empty", empty_out, 4'hF);
      chk("midop_rst_flags", {active_out, full_in}, 5'h0);
      tick();
      reset = 1'b0;
      tick();
      // strict priority: ingress 0 and 2 loaded together, all ch0 words must leave first
      s_init = 1'b1;
      tick();
      s_init = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         s_push = 4'b0101;
         s_data_in[0 +: 12] = w(3, 0, k);
         s_data_in[24 +: 12] = w(3, 2, k);
         tick();
      end
      s_push = '0;
      for (int k = 0; k < 4; k++) s_exp_q[3].push_back(w(3, 0, k));
      for (int k = 0; k < 4; k++) s_exp_q[3].push_back(w(3, 2, k));
      s_pop[3] = 1'b1;
      repeat (16) tick();
      s_pop = '0;
      tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("drained_egress%0d", c), exp_q[c].size(), 0);
         chk($sformatf("drained_strict%0d", c), s_exp_q[c].size(), 0);
      end
      chk("drained_reads", rd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
